// File: rtl/csi2_packet_parser_if.sv
// CSI-2 packet parser bus: aligned lane words in, payload and sync events out.
// slave is the parser's view; master is the upstream/downstream harness view.
interface csi2_packet_parser_if;
  logic            data_in_enable;
  logic [3:0][7:0] data_in;
  logic            data_enable;
  logic [3:0][7:0] data;
  logic [2:0]      data_bytes_valid;
  logic            interrupt;
  logic            frame_start;
  logic            frame_end;
  logic            line_start;
  logic            line_end;
  logic            header_error;
  logic            truncated;

  modport slave (
    input  data_in_enable, data_in,
    output data_enable, data, data_bytes_valid, interrupt,
           frame_start, frame_end, line_start, line_end,
           header_error, truncated
  );

  modport master (
    output data_in_enable, data_in,
    input  data_enable, data, data_bytes_valid, interrupt,
           frame_start, frame_end, line_start, line_end,
           header_error, truncated
  );
endinterface

// File: rtl/csi2_packet_parser.sv
// CSI-2 packet parser: checks header ECC, decodes frame/line sync short
// packets and strips header and CRC from accepted long packets. Every output
// is registered, one cycle after the word that caused it.
module csi2_packet_parser #(
  parameter logic [5:0] ACCEPT_DATA_TYPE       = 6'h2A,
  parameter logic [1:0] ACCEPT_VIRTUAL_CHANNEL = 2'd0
) (
  input  logic                 clk,
  input  logic                 reset,
  csi2_packet_parser_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PAYLOAD = 2'd1,
    ST_DROP    = 2'd2
  } state_t;

  // Hamming parity over the 24 header bits; the top two ECC bits are zero.
  function automatic logic [7:0] header_ecc(input logic [23:0] d);
    logic [5:0] p;
    p[0] = d[0] ^ d[1] ^ d[2] ^ d[4] ^ d[5] ^ d[7] ^ d[10] ^ d[11] ^ d[13] ^
           d[16] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    p[1] = d[0] ^ d[1] ^ d[3] ^ d[4] ^ d[6] ^ d[8] ^ d[10] ^ d[12] ^ d[14] ^
           d[17] ^ d[20] ^ d[21] ^ d[22] ^ d[23];
    p[2] = d[0] ^ d[2] ^ d[3] ^ d[5] ^ d[6] ^ d[9] ^ d[11] ^ d[12] ^ d[15] ^
           d[18] ^ d[20] ^ d[21] ^ d[22];
    p[3] = d[1] ^ d[2] ^ d[3] ^ d[7] ^ d[8] ^ d[9] ^ d[13] ^ d[14] ^ d[15] ^
           d[19] ^ d[20] ^ d[21] ^ d[23];
    p[4] = d[4] ^ d[5] ^ d[6] ^ d[7] ^ d[8] ^ d[9] ^ d[16] ^ d[17] ^ d[18] ^
           d[19] ^ d[20] ^ d[22] ^ d[23];
    p[5] = d[10] ^ d[11] ^ d[12] ^ d[13] ^ d[14] ^ d[15] ^ d[16] ^ d[17] ^
           d[18] ^ d[19] ^ d[21] ^ d[22] ^ d[23];
    return {2'b00, p};
  endfunction

  state_t          state_r, state_s;
  logic [15:0]     remaining_r, remaining_s;
  logic            data_enable_r, data_enable_s;
  logic [3:0][7:0] data_r, data_s;
  logic [2:0]      bytes_valid_r, bytes_valid_s;
  logic            interrupt_r, interrupt_s;
  // bit 0 frame_start, 1 frame_end, 2 line_start, 3 line_end
  logic [3:0]      flags_r, flags_s;
  logic            header_error_r, header_error_s;
  logic            truncated_r, truncated_s;

  // Header fields, valid only when the current word is a header.
  logic [1:0]  vc_s;
  logic [5:0]  dt_s;
  logic [15:0] wc_s;
  logic        ecc_ok_s;
  logic [2:0]  step_s;
  logic [3:0]  lane_keep_s;

  assign vc_s     = bus.data_in[0][7:6];
  assign dt_s     = bus.data_in[0][5:0];
  assign wc_s     = {bus.data_in[2], bus.data_in[1]};
  assign ecc_ok_s = (bus.data_in[3] ==
                     header_ecc({bus.data_in[2], bus.data_in[1], bus.data_in[0]}));
  // Bytes consumed by this payload word: min(4, remaining), so no underflow.
  assign step_s   = (remaining_r >= 16'd4) ? 3'd4 : remaining_r[2:0];

  // Lanes carrying payload; lanes beyond the count (CRC/filler) are zeroed.
  always_comb begin
    lane_keep_s = 4'b1111;
    case (step_s)
      3'd1:    lane_keep_s = 4'b0001;
      3'd2:    lane_keep_s = 4'b0011;
      3'd3:    lane_keep_s = 4'b0111;
      default: lane_keep_s = 4'b1111;
    endcase
  end

  // Next-state and next-output logic for the header/payload/drop sequencer.
  always_comb begin
    state_s        = state_r;
    remaining_s    = remaining_r;
    data_enable_s  = 1'b0;
    data_s         = data_r;
    bytes_valid_s  = bytes_valid_r;
    interrupt_s    = 1'b0;
    flags_s        = flags_r;
    header_error_s = 1'b0;
    truncated_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.data_in_enable) begin
          state_s = ST_DROP;
          if (!ecc_ok_s) begin
            header_error_s = 1'b1;
          end else if (vc_s != ACCEPT_VIRTUAL_CHANNEL) begin
            state_s = ST_DROP;
          end else if (dt_s < 6'h10) begin
            if (dt_s <= 6'h03) begin
              interrupt_s = 1'b1;
              flags_s     = 4'b0001 << dt_s[1:0];
            end else begin
              flags_s = flags_r;
            end
          end else if ((dt_s == ACCEPT_DATA_TYPE) && (wc_s != 16'h0000)) begin
            remaining_s = wc_s;
            state_s     = ST_PAYLOAD;
          end else begin
            state_s = ST_DROP;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_PAYLOAD: begin
        if (bus.data_in_enable) begin
          data_enable_s = 1'b1;
          bytes_valid_s = step_s;
          for (int i = 0; i < 4; i++) begin
            data_s[i] = lane_keep_s[i] ? bus.data_in[i] : 8'h00;
          end
          remaining_s = remaining_r - {13'd0, step_s};
          if (remaining_r == {13'd0, step_s}) begin
            state_s = ST_DROP;
          end else begin
            state_s = ST_PAYLOAD;
          end
        end else begin
          truncated_s = 1'b1;
          state_s     = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (bus.data_in_enable) begin
          state_s = ST_DROP;
        end else begin
          state_s = ST_IDLE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r        <= ST_IDLE;
      remaining_r    <= 16'h0000;
      data_enable_r  <= 1'b0;
      data_r         <= 32'h0000_0000;
      bytes_valid_r  <= 3'd0;
      interrupt_r    <= 1'b0;
      flags_r        <= 4'b0000;
      header_error_r <= 1'b0;
      truncated_r    <= 1'b0;
    end else begin
      state_r        <= state_s;
      remaining_r    <= remaining_s;
      data_enable_r  <= data_enable_s;
      data_r         <= data_s;
      bytes_valid_r  <= bytes_valid_s;
      interrupt_r    <= interrupt_s;
      flags_r        <= flags_s;
      header_error_r <= header_error_s;
      truncated_r    <= truncated_s;
    end
  end

  assign bus.data_enable      = data_enable_r;
  assign bus.data             = data_r;
  assign bus.data_bytes_valid = bytes_valid_r;
  assign bus.interrupt        = interrupt_r;
  assign bus.frame_start      = flags_r[0];
  assign bus.frame_end        = flags_r[1];
  assign bus.line_start       = flags_r[2];
  assign bus.line_end         = flags_r[3];
  assign bus.header_error     = header_error_r;
  assign bus.truncated        = truncated_r;

endmodule

// File: tb/tb_csi2_packet_parser.sv
// Self-checking bench for csi2_packet_parser: directed scenarios plus
// randomized packets against a byte-level reference model.
module tb_csi2_packet_parser;

  logic clk = 1'b0;
  logic reset;
  csi2_packet_parser_if bus();

  csi2_packet_parser #(
    .ACCEPT_DATA_TYPE      (6'h2A),
    .ACCEPT_VIRTUAL_CHANNEL(2'd0)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  // Syndrome column of each header bit (bit i of a column = parity Pi uses it).
  localparam logic [5:0] ECC_COL [24] = '{
    6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
    6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
    6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B};

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] burst[$];
  logic [34:0] exp_q[$];
  logic [34:0] obs_q[$];
  int exp_irq = 0, obs_irq = 0;
  int exp_herr = 0, obs_herr = 0;
  int exp_trunc = 0, obs_trunc = 0;
  int obs_overlap = 0;
  logic [3:0] exp_flags = 4'b0000;

  function automatic logic [7:0] ecc_ref(input logic [23:0] d);
    logic [5:0] s;
    s = 6'd0;
    for (int i = 0; i < 24; i++) if (d[i]) s = s ^ ECC_COL[i];
    return {2'b00, s};
  endfunction

  function automatic logic [31:0] hdr(input logic [1:0] vc, input logic [5:0] dt,
                                      input logic [15:0] wc);
    logic [23:0] d;
    d = {wc, vc, dt};
    return {ecc_ref(d), d};
  endfunction

  function automatic logic [3:0] dut_flags();
    return {bus.line_end, bus.line_start, bus.frame_end, bus.frame_start};
  endfunction

  // Observe outputs away from the active edge.
  always @(negedge clk) begin
    if (bus.data_enable === 1'b1) obs_q.push_back({bus.data_bytes_valid, bus.data});
    if (bus.interrupt === 1'b1) obs_irq++;
    if (bus.header_error === 1'b1) obs_herr++;
    if (bus.truncated === 1'b1) obs_trunc++;
    if (bus.data_enable === 1'b1 && bus.interrupt === 1'b1) obs_overlap++;
  end

  // Reference: what one burst (header in burst[0]) must produce.
  task automatic model_burst();
    logic [31:0] h;
    logic [31:0] m;
    int rem, k;
    h = burst[0];
    if (h[31:24] != ecc_ref(h[23:0])) begin
      exp_herr++;
    end else if (h[7:6] == 2'd0) begin
      if (h[5:0] < 6'h10) begin
        if (h[5:0] <= 6'h03) begin
          exp_irq++;
          exp_flags = 4'b0001 << h[1:0];
        end
      end else if (h[5:0] == 6'h2A && h[23:8] != 16'h0000) begin
        rem = int'(h[23:8]);
        for (int w = 1; w < burst.size() && rem > 0; w++) begin
          k = (rem > 4) ? 4 : rem;
          m = 32'h0;
          for (int b = 0; b < k; b++) m[8*b +: 8] = 8'hFF;
          exp_q.push_back({3'(k), burst[w] & m});
          rem -= k;
        end
        if (rem > 0) exp_trunc++;
      end
    end
  endtask

  task automatic send_burst(input int gap);
    model_burst();
    for (int i = 0; i < burst.size(); i++) begin
      @(posedge clk); #1;
      bus.data_in_enable = 1'b1;
      bus.data_in = burst[i];
    end
    @(posedge clk); #1;
    bus.data_in_enable = 1'b0;
    bus.data_in = 32'h0;
    repeat (gap - 1) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    repeat (3) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add_words(input int n);
    for (int i = 0; i < n; i++) burst.push_back($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.data_in_enable = 1'b0;
    bus.data_in = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (bus.data_enable !== 1'b0) begin n_err++; $display("FAIL reset_de: got %b want 0", bus.data_enable); end
    n_vec++; if (bus.interrupt !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", bus.interrupt); end
    n_vec++; if (bus.header_error !== 1'b0) begin n_err++; $display("FAIL reset_herr: got %b want 0", bus.header_error); end
    n_vec++; if (bus.truncated !== 1'b0) begin n_err++; $display("FAIL reset_trunc: got %b want 0", bus.truncated); end
    n_vec++; if (dut_flags() !== 4'b0000) begin n_err++; $display("FAIL reset_flags: got %b want 0000", dut_flags()); end
    n_vec++; if (bus.data !== 32'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", bus.data); end
    n_vec++; if (bus.data_bytes_valid !== 3'd0) begin n_err++; $display("FAIL reset_bv: got %0d want 0", bus.data_bytes_valid); end
    // A frame-start header presented while reset is high is dropped.
    @(posedge clk); #1;
    bus.data_in_enable = 1'b1;
    bus.data_in = 32'h0;
    @(posedge clk); #1;
    reset = 1'b0;
    bus.data_in_enable = 1'b0;
    @(negedge clk);
    n_vec++; if ({bus.interrupt, dut_flags()} !== 5'b0) begin n_err++; $display("FAIL reset_drop: got %b want 00000", {bus.interrupt, dut_flags()}); end
    repeat (2) @(posedge clk);
  endtask

  task automatic test_frame_start();
    @(posedge clk); #1;
    bus.data_in_enable = 1'b1;
    bus.data_in = 32'h0000_0000;
    @(posedge clk); #1;
    bus.data_in_enable = 1'b0;
    exp_irq++;
    exp_flags = 4'b0001;
    @(negedge clk);
    n_vec++; if (bus.interrupt !== 1'b1) begin n_err++; $display("FAIL fs_irq: got %b want 1", bus.interrupt); end
    n_vec++; if (dut_flags() !== 4'b0001) begin n_err++; $display("FAIL fs_flags: got %b want 0001", dut_flags()); end
    n_vec++; if (bus.data_enable !== 1'b0) begin n_err++; $display("FAIL fs_de: got %b want 0", bus.data_enable); end
    repeat (3) @(negedge clk);
    n_vec++; if ({bus.interrupt, dut_flags()} !== 5'b0_0001) begin n_err++; $display("FAIL fs_hold: got %b want 00001", {bus.interrupt, dut_flags()}); end
  endtask

  task automatic test_raw8_line();
    burst.delete();
    burst.push_back(hdr(2'd0, 6'h2A, 16'h0280));
    add_words(161);
    send_burst(1);
    drain();
    n_vec++; if (obs_q.size() !== 160) begin n_err++; $display("FAIL line_count: got %0d want 160", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL line_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_partial_word();
    burst.delete();
    burst.push_back(hdr(2'd0, 6'h2A, 16'd6));
    burst.push_back(32'h0403_0201);
    burst.push_back(32'hBBAA_0605);
    model_burst();
    @(posedge clk); #1;
    bus.data_in_enable = 1'b1; bus.data_in = burst[0];
    @(posedge clk); #1;
    bus.data_in = burst[1];
    @(negedge clk);
    n_vec++; if (bus.data_enable !== 1'b0) begin n_err++; $display("FAIL part_hdr_de: got %b want 0", bus.data_enable); end
    @(posedge clk); #1;
    bus.data_in = burst[2];
    @(negedge clk);
    n_vec++; if ({bus.data_enable, bus.data_bytes_valid, bus.data} !== {1'b1, 3'd4, 32'h0403_0201}) begin
      n_err++; $display("FAIL part_word1: got %b/%0d/%h want 1/4/04030201", bus.data_enable, bus.data_bytes_valid, bus.data); end
    @(posedge clk); #1;
    bus.data_in_enable = 1'b0; bus.data_in = 32'h0;
    @(negedge clk);
    n_vec++; if ({bus.data_enable, bus.data_bytes_valid, bus.data} !== {1'b1, 3'd2, 32'h0000_0605}) begin
      n_err++; $display("FAIL part_word2: got %b/%0d/%h want 1/2/00000605", bus.data_enable, bus.data_bytes_valid, bus.data); end
    @(negedge clk);
    n_vec++; if ({bus.data_enable, bus.truncated} !== 2'b00) begin n_err++; $display("FAIL part_after: got %b want 00", {bus.data_enable, bus.truncated}); end
    drain();
    n_vec++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL part_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_bad_ecc();
    int h0;
    h0 = obs_herr;
    burst.delete();
    burst.push_back(hdr(2'd0, 6'h2A, 16'd40) ^ (32'h1 << $urandom_range(0, 31)));
    add_words(11);
    send_burst(1);
    drain();
    n_vec++; if (obs_herr - h0 !== 1) begin n_err++; $display("FAIL ecc_pulse: got %0d want 1", obs_herr - h0); end
    n_vec++; if (obs_q.size() !== 0) begin n_err++; $display("FAIL ecc_data: got %0d words want 0", obs_q.size()); end
    burst.delete();
    burst.push_back(hdr(2'd0, 6'h2A, 16'd12));
    add_words(4);
    send_burst(1);
    drain();
    n_vec++; if (obs_q.size() !== 3) begin n_err++; $display("FAIL ecc_next_count: got %0d want 3", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL ecc_next_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_filtering();
    burst.delete();
    burst.push_back(hdr(2'd0, 6'h12, 16'd64));
    add_words(17);
    send_burst(1);
    burst.delete();
    burst.push_back(hdr(2'd1, 6'h00, 16'h0000));
    send_burst(1);
    drain();
    n_vec++; if (obs_q.size() !== 0) begin n_err++; $display("FAIL filt_data: got %0d words want 0", obs_q.size()); end
    n_vec++; if (obs_irq !== exp_irq) begin n_err++; $display("FAIL filt_irq: got %0d want %0d", obs_irq, exp_irq); end
    n_vec++; if (dut_flags() !== exp_flags) begin n_err++; $display("FAIL filt_flags: got %b want %b", dut_flags(), exp_flags); end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_truncation();
    int t0;
    t0 = obs_trunc;
    burst.delete();
    burst.push_back(hdr(2'd0, 6'h2A, 16'h0280));
    add_words(3);
    send_burst(1);
    drain();
    n_vec++; if (obs_q.size() !== 3) begin n_err++; $display("FAIL trunc_count: got %0d want 3", obs_q.size()); end
    n_vec++; if (obs_trunc - t0 !== 1) begin n_err++; $display("FAIL trunc_pulse: got %0d want 1", obs_trunc - t0); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL trunc_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_mid_payload();
    burst.delete();
    burst.push_back(hdr(2'd0, 6'h2A, 16'd40));
    add_words(5);
    for (int i = 1; i <= 4; i++) exp_q.push_back({3'd4, burst[i]});
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus.data_in_enable = 1'b1; bus.data_in = burst[i];
    end
    @(posedge clk); #1;
    reset = 1'b1; bus.data_in = burst[5];
    @(posedge clk); #1;
    reset = 1'b0; bus.data_in_enable = 1'b0; bus.data_in = 32'h0;
    exp_flags = 4'b0000;
    @(negedge clk);
    n_vec++; if ({bus.data_enable, bus.interrupt, bus.header_error, bus.truncated, dut_flags(), bus.data_bytes_valid, bus.data} !== 43'd0) begin
      n_err++; $display("FAIL rst_mid_outputs: got de=%b irq=%b herr=%b tr=%b fl=%b bv=%0d d=%h want all 0",
        bus.data_enable, bus.interrupt, bus.header_error, bus.truncated, dut_flags(), bus.data_bytes_valid, bus.data); end
    drain();
    n_vec++; if (obs_q.size() !== 4) begin n_err++; $display("FAIL rst_mid_count: got %0d want 4", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rst_mid_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
    burst.delete();
    burst.push_back(hdr(2'd0, 6'h02, 16'h1234));
    send_burst(1);
    drain();
    n_vec++; if (dut_flags() !== 4'b0100) begin n_err++; $display("FAIL rst_next_flags: got %b want 0100", dut_flags()); end
    n_vec++; if (obs_irq !== exp_irq) begin n_err++; $display("FAIL rst_next_irq: got %0d want %0d", obs_irq, exp_irq); end
  endtask

  task automatic test_wc_max();
    int t0;
    t0 = obs_trunc;
    burst.delete();
    burst.push_back(hdr(2'd0, 6'h2A, 16'hFFFF));
    add_words(16385);
    send_burst(1);
    drain();
    n_vec++; if (obs_q.size() !== 16384) begin n_err++; $display("FAIL wcmax_count: got %0d want 16384", obs_q.size()); end
    n_vec++; if (obs_trunc !== t0) begin n_err++; $display("FAIL wcmax_trunc: got %0d want %0d", obs_trunc, t0); end
    if (obs_q.size() > 0) begin
      n_vec++; if (obs_q[obs_q.size()-1][34:32] !== 3'd3) begin n_err++; $display("FAIL wcmax_last_bv: got %0d want 3", obs_q[obs_q.size()-1][34:32]); end
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL wcmax_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    int kind, nw;
    logic [15:0] wc;
    for (int p = 0; p < 60; p++) begin
      burst.delete();
      kind = $urandom_range(0, 7);
      wc = 16'($urandom_range(1, 40));
      nw = (int'(wc) + 5) / 4;
      case (kind)
        0: burst.push_back(hdr(2'd0, 6'($urandom_range(0, 3)), 16'($urandom)));
        1: burst.push_back(hdr(2'd0, 6'($urandom_range(4, 15)), 16'($urandom)));
        2, 3, 4: begin burst.push_back(hdr(2'd0, 6'h2A, wc)); add_words(nw); end
        5: begin
          wc = 16'($urandom_range(5, 40));
          burst.push_back(hdr(2'd0, 6'h2A, wc));
          add_words($urandom_range(1, (int'(wc) - 1) / 4));
        end
        6: begin burst.push_back(hdr(2'd0, 6'h2A, wc) ^ (32'h1 << $urandom_range(0, 31))); add_words(nw); end
        7: begin
          if ($urandom_range(0, 1) == 0) burst.push_back(hdr(2'($urandom_range(1, 3)), 6'h2A, wc));
          else burst.push_back(hdr(2'd0, 6'($urandom_range(16, 63)), wc));
          add_words(nw);
        end
        default: burst.push_back(hdr(2'd0, 6'h00, 16'h0000));
      endcase
      send_burst($urandom_range(1, 3));
    end
    drain();
    n_vec++; if (obs_q.size() !== exp_q.size()) begin n_err++; $display("FAIL rand_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_vec++; if (obs_q[i] !== exp_q[i]) begin n_err++; $display("FAIL rand_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
    end
    n_vec++; if (dut_flags() !== exp_flags) begin n_err++; $display("FAIL rand_flags: got %b want %b", dut_flags(), exp_flags); end
    obs_q.delete(); exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_frame_start();
    test_raw8_line();
    test_partial_word();
    test_bad_ecc();
    test_filtering();
    test_truncation();
    test_reset_mid_payload();
    test_wc_max();
    test_random();
    n_vec++; if (obs_irq !== exp_irq) begin n_err++; $display("FAIL total_irq: got %0d want %0d", obs_irq, exp_irq); end
    n_vec++; if (obs_herr !== exp_herr) begin n_err++; $display("FAIL total_herr: got %0d want %0d", obs_herr, exp_herr); end
    n_vec++; if (obs_trunc !== exp_trunc) begin n_err++; $display("FAIL total_trunc: got %0d want %0d", obs_trunc, exp_trunc); end
    n_vec++; if (obs_overlap !== 0) begin n_err++; $display("FAIL de_irq_overlap: got %0d want 0", obs_overlap); end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/csi2_packet_parser.md
# csi2_packet_parser

Single-clock CSI-2 packet parser between the 4-lane byte aligner and the frame-buffer arbiter. Consumes lane-aligned 32-bit words, checks each packet header's ECC, and decodes short packets into frame/line sync events. Strips headers and CRC from accepted long packets. Emits the payload in the `mipi_data_enable` / `mipi_data[3:0]` / `frame_start` / `line_start` / `interrupt` form the arbiter consumes.

## Interface
- `ACCEPT_DATA_TYPE`, default 6'h2A (RAW8): the only long-packet data type forwarded; all other long types are discarded.
- `ACCEPT_VIRTUAL_CHANNEL`, default 2'd0: packets on other virtual channels are discarded, including short packets.
- `clk`  in  1  mipi byte clock; single clock domain.
- `reset`  in  1  synchronous, active-high.
- `data_in_enable`  in  1  aligned word valid; high contiguously for one whole packet, low for at least 1 cycle between packets.
- `data_in`  in  [7:0] x [3:0]  lane bytes; `data_in[0]` is the earliest byte of the word.
- `data_enable`  out  1  payload word valid.
- `data`  out  [7:0] x [3:0]  payload bytes in the same byte order as the input.
- `data_bytes_valid`  out  3  number of valid bytes in `data`, from `data[0]` upward (1..4); only meaningful with `data_enable`.
- `interrupt`  out  1  one-cycle pulse per accepted short packet.
- `frame_start`, `frame_end`, `line_start`, `line_end`  out  1 each  type of the most recent accepted short packet; exactly one set after the first one, held until the next.
- `header_error`  out  1  pulse: header ECC mismatch.
- `truncated`  out  1  pulse: `data_in_enable` fell before the payload completed.

## Operation
- Header is the first word of every burst:
  - `data_in[0]` = DataID (VC[7:6], DT[5:0]).
  - `data_in[1]` = WC[7:0].
  - `data_in[2]` = WC[15:8].
  - `data_in[3]` = ECC.
- ECC check:
  - P0..P5 are computed per CSI-2 Hamming equations over the 24 header bits; expected ECC = {2'b00, P5..P0}.
  - Detect only, no correction.
  - On mismatch: pulse `header_error` and enter DROP.
- Short packet (DT < 6'h10, ECC ok, VC matches):
  - DT 0x00/0x01/0x02/0x03 set `frame_start`/`frame_end`/`line_start`/`line_end` respectively, clear the other three, and pulse `interrupt`.
  - Other short DTs are ignored with no pulse.
  - Next state DROP.
- Long packet, ECC ok, DT == `ACCEPT_DATA_TYPE`, VC matches, WC != 0:
  - Load 16-bit `remaining` = WC; next state PAYLOAD.
- Any other long packet, or WC == 0: DROP.
- States:
  - IDLE: waits for a rising `data_in_enable` and parses the header.
  - PAYLOAD: each enabled word emits `data_bytes_valid` = min(4, remaining) and decrements `remaining` by the same amount. When `remaining` reaches 0, go to DROP, which discards the trailing CRC and filler bytes.
  - DROP: discards words until `data_in_enable` is low, then goes to IDLE.
- IDLE is entered only from a cycle with `data_in_enable` low, so words after a header are never reparsed as headers.
- Boundaries:
  - `data_in_enable` low during PAYLOAD with `remaining` > 0: pulse `truncated`, go to IDLE, emit nothing further.
  - A payload that ends mid-word (WC mod 4 != 0): the last word carries the partial count, and the CRC bytes in the upper lanes are never presented as data.
  - WC = 0xFFFF: counts correctly with no wrap; `remaining` never underflows.
  - `reset` in any state: IDLE next cycle; any word being presented in that cycle is dropped.
- CRC is not checked.

## Timing
- All outputs are registered; latency is 1 cycle from the input word to its output.
  - A header at cycle N produces `interrupt` or `header_error` at N+1.
  - A payload word at cycle M produces `data_enable` at M+1.
  - A falling edge of `data_in_enable` at cycle K produces `truncated` at K+1.
- No backpressure; downstream must accept one word per cycle.
- Reset values (all outputs, including the four type flags, which stay low until the first accepted short packet):
  - `data_enable` = 0, `interrupt` = 0, `header_error` = 0, `truncated` = 0.
  - `frame_start` = `frame_end` = `line_start` = `line_end` = 0.
  - `data` = 0, `data_bytes_valid` = 0.
- `data_enable` is never high in the same cycle as `interrupt`.
- Minimum packet spacing is 1 idle cycle; back-to-back packets are supported at that spacing.

## Test plan
- Frame start:
  - Stimulus: header {00,00,00,00} for 1 cycle, then enable low.
  - Required: `interrupt`=1 and `frame_start`=1 at +1 cycle; `frame_start` stays 1; no `data_enable`.
- RAW8 line:
  - Stimulus: header {2A,80,02,ECC}, then 161 words (160 payload words plus one CRC/filler word).
  - Required: exactly 160 `data_enable` cycles with `data_bytes_valid`=4 and data matching the input bytes; the CRC word is suppressed.
- Partial last word:
  - Stimulus: WC=6 with payload bytes 01..06 followed by CRC AA,BB.
  - Required: word1 = 01,02,03,04 with `data_bytes_valid`=4; word2 has `data_bytes_valid`=2 with 05,06 in `data[0]`,`data[1]`.
- Bad ECC:
  - Stimulus: flip one bit of a valid RAW8 header.
  - Required: `header_error` pulse; zero `data_enable` for the whole burst; the next valid packet parses normally.
- Filtering:
  - Stimulus: DT 0x12 with WC=64; a frame-start short packet with VC=1.
  - Required: no `data_enable`; no `interrupt`; flags unchanged.
- Truncation and reset:
  - Stimulus: drop enable after 3 of 160 payload words.
  - Required: 3 `data_enable` cycles, then a `truncated` pulse.
  - Stimulus: assert `reset` mid-payload.
  - Required: all outputs 0 at +1 cycle; the next header is parsed correctly.
